vga_sync_gen: RTL and testbench
===============================

# vga_sync_gen

Raster timing generator and pixel output stage for the 640x480 display path. It scans the frame and drives the `x`/`y` coordinates into the video encoder. It then takes the encoder's registered 1-bit `px_data` back, aligns it with delayed sync and blanking, and drives the VGA connector. It also emits a per-frame tick that the game logic uses to advance ball and paddle state during vertical blanking.

## Interface
- `H_ACTIVE`, default 640: visible pixels per line
- `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal porch and sync widths, in pixels
- `V_ACTIVE`, default 480: visible lines
- `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical porch and sync widths, in lines
- `CLK_DIV`, default 4: clk cycles per pixel; legal range 1..16
- `FG_RGB`, default 12'hFFF: colour driven when `px_data`=1
- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `px_data`  in  1  pixel bit from the encoder; reflects the previous pixel position
- `x`  out  11  current horizontal scan position, 0..H_TOTAL-1
- `y`  out  11  current vertical scan position, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync, active-low
- `vsync`  out  1  vertical sync, active-low
- `rgb`  out  12  4:4:4 colour; zero outside the active area
- `pix_ce`  out  1  one-clk strobe marking a pixel step
- `frame_tick`  out  1  one-clk pulse at the start of vertical blank

## Operation
- Totals are derived: `H_TOTAL` = sum of the H_* parameters (800); `V_TOTAL` = sum of the V_* parameters (525).
- Pixel divider: a counter runs 0..CLK_DIV-1; `pix_ce`=1 when it equals CLK_DIV-1. All other state advances only on `pix_ce`.
- Horizontal counter `x`: increments on each `pix_ce`; wraps from H_TOTAL-1 to 0.
- Vertical counter `y`: increments on the `x` wrap; wraps from V_TOTAL-1 to 0. When both wrap together, the result is (0,0).
- Decoded for the current position:
  - active = `x`<H_ACTIVE && `y`<V_ACTIVE
  - hs = `x` in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs = `y` in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
- Output stage, registered on `pix_ce`, one pixel behind the counters:
  - `hsync` <= ~hs_d and `vsync` <= ~vs_d, where hs_d/vs_d are hs/vs of the previous position.
  - `rgb` <= (active_d && `px_data`) ? FG_RGB : 0.
- `frame_tick`: asserted in the same clk as the `pix_ce` that moves the counters to (0, V_ACTIVE); deasserted otherwise.
- Counters have no other stop or load; the block free-runs from reset release.

## Timing
- Reset values: divider 0, `x`=0, `y`=0, `hsync`=1, `vsync`=1, `rgb`=0, `pix_ce`=0, `frame_tick`=0, delayed-decode registers 0 (inactive).
- Reset asserts asynchronously; first `pix_ce` occurs CLK_DIV clks after `rst_n` rises. A reset mid-line returns all state to the reset values immediately.
- Latency contract with the encoder:
  - The encoder registers `px_data` 1 clk after `x`/`y` change.
  - The output stage samples it CLK_DIV clks after the change, so CLK_DIV=1 is legal.
  - The pixel at position P appears on `rgb` one pixel period after `x`/`y`=P.
- `hsync`/`vsync`/`rgb` change only in the clk following a `pix_ce`.
- Line period = H_TOTAL×CLK_DIV clks; frame period = H_TOTAL×V_TOTAL×CLK_DIV clks (1,680,000 at defaults).

## Configuration
- `VGA_PIXEL_DIV_EN` defined: the divider is built as described and `CLK_DIV` applies.
- `VGA_PIXEL_DIV_EN` undefined: no divider; `pix_ce` is tied to 1 and every clk is one pixel; `CLK_DIV` is ignored. Use this when `clk` is already 25 MHz.

## Structure
- Shared `video_pkg` holds:
  - the default 640x480 timing constants
  - coordinate width (11)
  - the `H_TOTAL`/`V_TOTAL` helper functions
  - the encoder, the game logic and this block all use `video_pkg`.
- One sub-module, `vga_pix_ce`: the parameterised clock-enable divider, compiled only under `VGA_PIXEL_DIV_EN`.
- Counters, decode and the output stage stay in `vga_sync_gen`.

## Test plan
- **Reset:** hold `rst_n`=0 for 10 clks, then release → outputs at reset values; first `pix_ce` 4 clks after release; `x` steps 0→1.
- **Line timing:** run 2 lines at CLK_DIV=4 → `hsync` low for exactly 384 clks, starting 1 pixel after `x`=656; line period 3200 clks.
- **Frame timing:** run 2 frames →
  - `vsync` low for 2 lines starting at `y`=490 (+1 pixel delay);
  - `frame_tick` once per frame, coincident with `x`,`y`=(0,480);
  - frame period 1,680,000 clks.
- **Pixel alignment:** echo model drives `px_data`=1 only for `x`=100,`y`=50 (registered 1 clk) → `rgb`=12'hFFF for exactly one pixel, during `x`=101 of line 50; zero elsewhere.
- **Blanking:** force `px_data`=1 constantly → `rgb`=0 whenever the delayed position is outside 640x480.
- **Mid-frame reset:** pulse `rst_n` low at `y`=300 → `x`,`y`, `hsync`, `vsync`, `rgb` return to reset values in the same clk; the rerun frame timing matches the reset case. Repeat with `VGA_PIXEL_DIV_EN` undefined → line period 800 clks.

Source files
------------

// File: rtl/video_pkg.sv
// Shared 640x480 timing constants, coordinate width and raster-total helpers.
// Used by the video encoder, the game logic and the sync generator.
package video_pkg;

    localparam int COORD_W = 11;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_pix_ce.sv
// Pixel clock-enable divider: one-clk pix_ce strobe every CLK_DIV clks.
// Latency: first strobe CLK_DIV-1 clks after reset release; free-running, no backpressure.
`ifdef VGA_PIXEL_DIV_EN
module vga_pix_ce #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_ce
);

    localparam logic [3:0] LAST = 4'(CLK_DIV - 1);

    logic [3:0] cnt;
    logic [3:0] cnt_nxt;

    assign cnt_nxt = (cnt == LAST) ? 4'd0 : cnt + 4'd1;

    // Strobe is registered so it stays low while in reset, even for CLK_DIV=1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= 4'd0;
            pix_ce <= 1'b0;
        end else begin
            cnt    <= cnt_nxt;
            pix_ce <= (cnt_nxt == LAST);
        end
    end

endmodule
`endif

// File: rtl/vga_sync_gen.sv
// Raster scan counters, sync/blank decode and pixel output stage for the VGA connector.
// Latency: hsync/vsync/rgb trail x/y by one pixel period; free-running, no backpressure.
// VGA_PIXEL_DIV_EN builds the CLK_DIV pixel divider; without it every clk is one pixel.
module vga_sync_gen
    import video_pkg::*;
#(
    parameter int          H_ACTIVE = H_ACTIVE_DEF,
    parameter int          H_FP     = H_FP_DEF,
    parameter int          H_SYNC   = H_SYNC_DEF,
    parameter int          H_BP     = H_BP_DEF,
    parameter int          V_ACTIVE = V_ACTIVE_DEF,
    parameter int          V_FP     = V_FP_DEF,
    parameter int          V_SYNC   = V_SYNC_DEF,
    parameter int          V_BP     = V_BP_DEF,
    parameter int          CLK_DIV  = 4,
    parameter logic [11:0] FG_RGB   = 12'hFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               px_data,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               hsync,
    output logic               vsync,
    output logic [11:0]        rgb,
    output logic               pix_ce,
    output logic               frame_tick
);

    localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] X_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] Y_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] X_ACT    = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] Y_ACT    = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] Y_VBLANK = COORD_W'(V_ACTIVE - 1);
    localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_div_range
        $error("vga_sync_gen: CLK_DIV must be in 1..16");
    end

`ifdef VGA_PIXEL_DIV_EN
    vga_pix_ce #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_ce (
        .clk    (clk),
        .rst_n  (rst_n),
        .pix_ce (pix_ce)
    );
`else
    assign pix_ce = 1'b1;
`endif

    logic               x_wrap;
    logic [COORD_W-1:0] x_nxt;
    logic [COORD_W-1:0] y_nxt;
    logic               active_nxt;
    logic               hs_nxt;
    logic               vs_nxt;

    always_comb begin
        x_wrap = (x == X_LAST);
        x_nxt  = x_wrap ? '0 : x + COORD_W'(1);
        y_nxt  = y;
        if (x_wrap) begin
            y_nxt = (y == Y_LAST) ? '0 : y + COORD_W'(1);
        end
        active_nxt = (x_nxt < X_ACT) && (y_nxt < Y_ACT);
        hs_nxt     = (x_nxt >= HS_BEG) && (x_nxt < HS_END);
        vs_nxt     = (y_nxt >= VS_BEG) && (y_nxt < VS_END);
    end

    assign frame_tick = pix_ce && x_wrap && (y == Y_VBLANK);

    // The *_d registers hold the decode of the position now on x/y, computed a step
    // early from x_nxt/y_nxt; the output stage consumes them as x/y move on.
    logic active_d;
    logic hs_d;
    logic vs_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            active_d <= 1'b0;
            hs_d     <= 1'b0;
            vs_d     <= 1'b0;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            rgb      <= '0;
        end else if (pix_ce) begin
            x        <= x_nxt;
            y        <= y_nxt;
            active_d <= active_nxt;
            hs_d     <= hs_nxt;
            vs_d     <= vs_nxt;
            hsync    <= ~hs_d;
            vsync    <= ~vs_d;
            rgb      <= (active_d && px_data) ? FG_RGB : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunk 24x16 raster with a behavioural raster model.
module tb_vga_sync_gen;

    localparam int HA = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA = 10, VF = 2, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;   // 24
    localparam int VT = VA + VF + VS + VB;   // 16
    localparam int FRAME = HT * VT;          // 384 pixels
    localparam logic [11:0] FG = 12'hA5C;
`ifdef VGA_PIXEL_DIV_EN
    localparam int DIV   = 3;
    localparam bit NODIV = 1'b0;
`else
    localparam int DIV   = 1;
    localparam bit NODIV = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        px_data = 1'b0;
    logic [10:0] x, y;
    logic        hsync, vsync, pix_ce, frame_tick;
    logic [11:0] rgb;

    int errors = 0;
    int checks = 0;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .CLK_DIV(3), .FG_RGB(FG)
    ) dut (
        .clk(clk), .rst_n(rst_n), .px_data(px_data),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pix_ce(pix_ce), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // ---------------- behavioural raster model ----------------
    bit pat [VT][HT];
    int c_m, steps, q_m, p_c;
    logic [11:0] rgb_m;
    logic hs_m, vs_m;
    bit cur_bit;

    function automatic bit is_active(input int q);
        return (q % HT) < HA && (q / HT) < VA;
    endfunction
    function automatic bit in_hs(input int q);
        return (q % HT) >= HA + HF && (q % HT) < HA + HF + HS;
    endfunction
    function automatic bit in_vs(input int q);
        return (q / HT) >= VA + VF && (q / HT) < VA + VF + VS;
    endfunction
    // Pixel strobe expected after c clk edges since reset release.
    function automatic bit pce(input int c);
        if (NODIV) return 1'b1;
        return ((c % DIV) == DIV - 1) && (c > 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_m = 0; steps = 0; rgb_m = 12'h000; hs_m = 1'b1; vs_m = 1'b1;
        end else begin
            if (pce(c_m)) begin
                q_m = steps % FRAME;
                if (steps == 0) begin
                    rgb_m = 12'h000; hs_m = 1'b1; vs_m = 1'b1;
                end else begin
                    rgb_m = (is_active(q_m) && cur_bit) ? FG : 12'h000;
                    hs_m  = !in_hs(q_m);
                    vs_m  = !in_vs(q_m);
                end
                steps++;
            end
            c_m++;
        end
    end

    // Encoder stand-in: pixel bit of the position currently on the scan.
    always @(posedge clk) begin
        #2;
        cur_bit = pat[(steps % FRAME) / HT][(steps % FRAME) % HT];
        px_data = cur_bit;
    end

    always @(negedge clk) begin
        p_c = steps % FRAME;
        chk("x", 32'(x), 32'(p_c % HT));
        chk("y", 32'(y), 32'(p_c / HT));
        chk("hsync", 32'(hsync), 32'(hs_m));
        chk("vsync", 32'(vsync), 32'(vs_m));
        chk("rgb", 32'(rgb), 32'(rgb_m));
        chk("pix_ce", 32'(pix_ce), 32'(pce(c_m)));
        chk("frame_tick", 32'(frame_tick), 32'(pce(c_m) && p_c == VA * HT - 1));
    end

    // ---------------- directed measurements ----------------
    task automatic fill(input int mode);
        for (int yy = 0; yy < VT; yy++)
            for (int xx = 0; xx < HT; xx++)
                pat[yy][xx] = (mode == 0) ? (xx == 5 && yy == 3) :
                              (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic startup_checks();
        int n;
        #1;
        chk("rst_x", 32'(x), 0);
        chk("rst_y", 32'(y), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_rgb", 32'(rgb), 0);
        chk("rst_frame_tick", 32'(frame_tick), 0);
        chk("rst_pix_ce", 32'(pix_ce), NODIV ? 1 : 0);
        n = 0;
        while (x == 0 && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk("first_step_clks", n, DIV);
        chk("first_step_x", 32'(x), 1);
    endtask

    task automatic window_checks(input int mode);
        int hs_t = -1, hs_low = -1, line_per = -1, hs_x = -1;
        int vs_t = -1, vs_low = -1, vs_per = -1, vs_x = -1, vs_y = -1;
        int ft_t = -1, ft_per = -1, ft_x = -1, ft_y = -1;
        int nz = 0, nz_x = -1, nz_y = -1, nz_v = -1;
        logic ph = 1'b1, pv = 1'b1;
        for (int cyc = 0; cyc < 2 * FRAME * DIV + 4 * HT * DIV; cyc++) begin
            @(negedge clk);
            if (ph && !hsync) begin
                if (hs_t >= 0 && line_per < 0) line_per = cyc - hs_t;
                if (hs_x < 0) hs_x = int'(x);
                hs_t = cyc;
            end
            if (!ph && hsync && hs_t >= 0 && hs_low < 0) hs_low = cyc - hs_t;
            if (pv && !vsync) begin
                if (vs_t >= 0 && vs_per < 0) vs_per = cyc - vs_t;
                if (vs_x < 0) begin vs_x = int'(x); vs_y = int'(y); end
                vs_t = cyc;
            end
            if (!pv && vsync && vs_t >= 0 && vs_low < 0) vs_low = cyc - vs_t;
            if (frame_tick) begin
                if (ft_t >= 0 && ft_per < 0) ft_per = cyc - ft_t;
                if (ft_t < 0) begin ft_x = int'(x); ft_y = int'(y); end
                ft_t = cyc;
            end
            if (ft_t >= 0 && ft_per < 0 && rgb != 12'h000) begin
                nz++; nz_x = int'(x); nz_y = int'(y); nz_v = int'(rgb);
            end
            ph = hsync;
            pv = vsync;
        end
        chk("hsync_fall_x", hs_x, 19);               // one pixel after HA+HF=18
        chk("hsync_low_clks", hs_low, 3 * DIV);
        chk("line_period_clks", line_per, 24 * DIV);
        chk("vsync_fall_y", vs_y, 12);
        chk("vsync_fall_x", vs_x, 1);
        chk("vsync_low_clks", vs_low, 48 * DIV);      // two 24-pixel lines
        chk("frame_period_clks", vs_per, 384 * DIV);
        chk("frame_tick_x", ft_x, 23);
        chk("frame_tick_y", ft_y, 9);
        chk("frame_tick_period", ft_per, 384 * DIV);
        if (mode == 0) begin
            chk("align_rgb_clks", nz, DIV);
            chk("align_x", nz_x, 6);
            chk("align_y", nz_y, 3);
            chk("align_rgb", nz_v, 32'h0A5C);
        end else if (mode == 1) begin
            chk("blank_lit_clks", nz, 160 * DIV);     // 16x10 visible pixels
        end
    endtask

    initial begin
        int n;
        fill(0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b1;
        startup_checks();
        window_checks(0);
        fill(1);
        window_checks(1);
        fill(2);
        window_checks(2);

        n = 0;
        while (!(y == 7 && x == 9) && n < 5000) begin
            @(posedge clk); #2; n++;
        end
        chk("reach_midframe_y", 32'(y), 7);
        rst_n = 1'b0;
        #1;
        chk("midrst_x", 32'(x), 0);
        chk("midrst_y", 32'(y), 0);
        chk("midrst_hsync", 32'(hsync), 1);
        chk("midrst_vsync", 32'(vsync), 1);
        chk("midrst_rgb", 32'(rgb), 0);
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b1;
        startup_checks();
        fill(0);
        window_checks(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
